hazard_stall_controller: RTL and testbench
==========================================

# hazard_stall_controller

Central hazard and stall controller for the five-stage pipeline. Drives the stall/flush enables of the F/D, D/E, E/M and M/W pipeline registers and the E-stage forwarding muxes. Sequences multi-cycle data-memory accesses in the M stage with a wait FSM and timeout. Resolves load-use, taken-branch and memory-wait hazards with a fixed priority.

## Interface
- DATA_WIDTH, 32, width of performance counters
- MAX_WAIT, 16, maximum M-stage wait cycles before timeout (1..255)

Ports:
- clk  in  1  clock; state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- Rs1D, Rs2D  in  5 each  source registers in D
- Rs1E, Rs2E, RdE  in  5 each  sources and destination in E
- ResultsSrcE  in  2  2'b01 marks a load in E
- PCSrcE  in  1  taken branch/jump resolved in E
- RdM, RdW  in  5 each  destinations in M, W
- RegWriteM, RegWriteW  in  1 each  write enables in M, W
- MemAccessM  in  1  load or store present in M
- MemReadyM  in  1  data memory completes access this cycle
- ForwardAE, ForwardBE  out  2 each  00 regfile, 10 from M, 01 from W
- StallF, StallD, StallE, StallM  out  1 each  hold pipeline register
- FlushD, FlushE, FlushW  out  1 each  bubble into register
- MemTimeout  out  1  sticky timeout error
- LoadUseCount, MemWaitCount, FlushCount  out  DATA_WIDTH each  performance counters

## Operation
- Forwarding (per operand, shown for A): 10 if RegWriteM && RdM!=0 && RdM==Rs1E; else 01 if RegWriteW && RdW!=0 && RdW==Rs1E; else 00. M beats W. B identical with Rs2E.
- lwStall = ResultsSrcE==2'b01 && RdE!=0 && (RdE==Rs1D || RdE==Rs2D).
- memStall = (state IDLE && MemAccessM && !MemReadyM) || state WAIT || state ERROR.
  - In WAIT, memStall drops in the cycle MemReadyM=1.
- FSM states: IDLE, WAIT, ERROR.
  - IDLE -> WAIT when MemAccessM && !MemReadyM; wait counter loads 1.
  - WAIT -> IDLE when MemReadyM=1.
  - WAIT -> ERROR when counter==MAX_WAIT && !MemReadyM; otherwise counter increments. Counter is 8 bits.
  - ERROR is absorbing until rst: MemTimeout=1, all stages stalled.
- Priority: memStall > PCSrcE > lwStall.
  - memStall: StallF=StallD=StallE=StallM=1, FlushW=1, FlushD=FlushE=0. Branch and load-use effects are masked; they reassert naturally when released because E and D are frozen.
  - Else PCSrcE: FlushD=FlushE=1, no stalls. The load-use stall is discarded because the D instruction is squashed.
  - Else lwStall: StallF=StallD=1, FlushE=1.
- Forwarding outputs are unaffected by stalls.

## Timing
- Forwarding, stall and flush outputs are combinational from inputs and current state, with zero-cycle latency.
- Reset values: state IDLE, wait counter 0, MemTimeout 0, all counters 0. While rst=1 all stall/flush outputs are 0.
- A hit (MemReadyM=1 in the first M cycle) adds 0 stall cycles. An access ready on wait cycle N stalls exactly N cycles.
- Timeout: ERROR is entered on the edge after MAX_WAIT wait cycles with no ready. MemReadyM arriving in that same cycle wins, and the FSM goes to IDLE instead.
- Reset asserted in WAIT or ERROR returns to IDLE immediately (asynchronously).

## Configuration
- HAZARD_PERF_EN defined:
  - LoadUseCount increments each cycle lwStall is applied.
  - MemWaitCount increments each cycle memStall=1.
  - FlushCount increments each cycle PCSrcE flush is applied.
  - Counters wrap modulo 2^DATA_WIDTH and clear on rst.
- HAZARD_PERF_EN undefined: counters and their logic are removed; the three outputs are tied to 0.

## Test plan
- Forwarding: RdM=RdW=5, RegWriteM=RegWriteW=1, Rs1E=5 -> ForwardAE=10. Set RegWriteM=0 -> 01. Set Rd=0 -> 00.
- Load-use: ResultsSrcE=01, RdE=3, Rs2D=3 -> StallF=StallD=FlushE=1 for one cycle. LoadUseCount=1 with HAZARD_PERF_EN.
- Branch plus load-use in the same cycle: PCSrcE=1 and lwStall conditions true -> FlushD=FlushE=1, StallF=0.
- Memory wait: MemAccessM=1, MemReadyM low 3 cycles then high -> all stages stalled with FlushW=1 for exactly 3 cycles, then IDLE. MemWaitCount=3.
- Timeout with MAX_WAIT=4: MemReadyM held 0 -> ERROR after 4 wait cycles, MemTimeout=1 and stalls held. Pulse rst -> IDLE with all outputs 0.
- Reset mid-WAIT: assert rst during cycle 2 of a wait -> state IDLE and stalls 0 immediately, with no clock edge needed.

Source files
------------

// File: rtl/hazard_stall_controller.sv
// hazard_stall_controller: pipeline forwarding, stall/flush control and M-stage wait FSM.
// Define HAZARD_PERF_EN to build the load-use, memory-wait and flush performance counters.
module hazard_stall_controller #(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_WAIT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4:0]            Rs1D,
  input  logic [4:0]            Rs2D,
  input  logic [4:0]            Rs1E,
  input  logic [4:0]            Rs2E,
  input  logic [4:0]            RdE,
  input  logic [1:0]            ResultsSrcE,
  input  logic                  PCSrcE,
  input  logic [4:0]            RdM,
  input  logic [4:0]            RdW,
  input  logic                  RegWriteM,
  input  logic                  RegWriteW,
  input  logic                  MemAccessM,
  input  logic                  MemReadyM,
  output logic [1:0]            ForwardAE,
  output logic [1:0]            ForwardBE,
  output logic                  StallF,
  output logic                  StallD,
  output logic                  StallE,
  output logic                  StallM,
  output logic                  FlushD,
  output logic                  FlushE,
  output logic                  FlushW,
  output logic                  MemTimeout,
  output logic [DATA_WIDTH-1:0] LoadUseCount,
  output logic [DATA_WIDTH-1:0] MemWaitCount,
  output logic [DATA_WIDTH-1:0] FlushCount
);
  localparam logic [1:0] IDLE = 2'd0, WAIT = 2'd1, ERROR = 2'd2;
  localparam logic [7:0] MAX_CNT = 8'(MAX_WAIT);
  logic [1:0] state;
  logic [7:0] wait_cnt;
  logic lw_stall, mem_stall, br_flush, lu_apply;
  always_comb begin
    ForwardAE = (RegWriteM && RdM != 5'd0 && RdM == Rs1E) ? 2'b10 :
                (RegWriteW && RdW != 5'd0 && RdW == Rs1E) ? 2'b01 : 2'b00;
    ForwardBE = (RegWriteM && RdM != 5'd0 && RdM == Rs2E) ? 2'b10 :
                (RegWriteW && RdW != 5'd0 && RdW == Rs2E) ? 2'b01 : 2'b00;
    lw_stall  = ResultsSrcE == 2'b01 && RdE != 5'd0 && (RdE == Rs1D || RdE == Rs2D);
    // rst gating keeps controls quiet even while an IDLE miss is presented
    mem_stall = !rst && ((state == IDLE && MemAccessM && !MemReadyM) ||
                         (state == WAIT && !MemReadyM) || state == ERROR);
    br_flush  = !rst && !mem_stall && PCSrcE;
    lu_apply  = !rst && !mem_stall && !PCSrcE && lw_stall;
    StallF    = mem_stall || lu_apply;
    StallD    = mem_stall || lu_apply;
    StallE    = mem_stall;
    StallM    = mem_stall;
    FlushW    = mem_stall;
    FlushD    = br_flush;
    FlushE    = br_flush || lu_apply;
    MemTimeout = state == ERROR;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      wait_cnt <= 8'd0;
    end else if (state == IDLE) begin
      if (MemAccessM && !MemReadyM) begin
        state    <= WAIT;
        wait_cnt <= 8'd1;
      end
    end else if (state == WAIT) begin
      if (MemReadyM) begin
        state    <= IDLE;
        wait_cnt <= 8'd0;
      end else if (wait_cnt == MAX_CNT) begin
        state <= ERROR;
      end else begin
        wait_cnt <= wait_cnt + 8'd1;
      end
    end
  end
`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      LoadUseCount <= '0;
      MemWaitCount <= '0;
      FlushCount   <= '0;
    end else begin
      LoadUseCount <= LoadUseCount + DATA_WIDTH'(lu_apply);
      MemWaitCount <= MemWaitCount + DATA_WIDTH'(mem_stall);
      FlushCount   <= FlushCount + DATA_WIDTH'(br_flush);
    end
  end
`else
  assign LoadUseCount = '0;
  assign MemWaitCount = '0;
  assign FlushCount   = '0;
`endif
endmodule

// File: tb/tb_hazard_stall_controller.sv
// tb_hazard_stall_controller: directed and random checks against a rule-level reference model.
module tb_hazard_stall_controller;
  localparam int DW = 32;
  localparam int MW = 4;
  logic clk = 0, rst = 1;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic [1:0] ResultsSrcE;
  logic PCSrcE, RegWriteM, RegWriteW, MemAccessM, MemReadyM;
  logic [1:0] ForwardAE, ForwardBE;
  logic StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemTimeout;
  logic [DW-1:0] LoadUseCount, MemWaitCount, FlushCount;
  int total = 0, bad = 0;
  bit m_err;
  int m_run;
  logic [DW-1:0] m_lu, m_mw, m_fl;

  hazard_stall_controller #(.DATA_WIDTH(DW), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst(rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .ResultsSrcE(ResultsSrcE), .PCSrcE(PCSrcE), .RdM(RdM), .RdW(RdW),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .MemAccessM(MemAccessM), .MemReadyM(MemReadyM),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .StallF(StallF), .StallD(StallD),
    .StallE(StallE), .StallM(StallM), .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .MemTimeout(MemTimeout), .LoadUseCount(LoadUseCount), .MemWaitCount(MemWaitCount),
    .FlushCount(FlushCount)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] fwd(input logic [4:0] rs);
    if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
    if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  // Memory stall: an open miss run continues until ready; error stalls forever.
  function automatic bit e_mem();
    if (rst) return 0;
    if (m_err) return 1;
    return m_run > 0 ? !MemReadyM : (MemAccessM && !MemReadyM);
  endfunction
  function automatic bit e_lw();
    return ResultsSrcE == 2'b01 && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
  endfunction
  function automatic bit e_br();
    return !rst && !e_mem() && PCSrcE;
  endfunction
  function automatic bit e_lu();
    return !rst && !e_mem() && !PCSrcE && e_lw();
  endfunction

  task automatic model_reset();
    m_err = 0; m_run = 0; m_lu = 0; m_mw = 0; m_fl = 0;
  endtask

  task automatic check_model();
    chk("ForwardAE", 32'(ForwardAE), 32'(fwd(Rs1E)));
    chk("ForwardBE", 32'(ForwardBE), 32'(fwd(Rs2E)));
    chk("StallF", 32'(StallF), 32'(e_mem() || e_lu()));
    chk("StallD", 32'(StallD), 32'(e_mem() || e_lu()));
    chk("StallE", 32'(StallE), 32'(e_mem()));
    chk("StallM", 32'(StallM), 32'(e_mem()));
    chk("FlushW", 32'(FlushW), 32'(e_mem()));
    chk("FlushD", 32'(FlushD), 32'(e_br()));
    chk("FlushE", 32'(FlushE), 32'(e_br() || e_lu()));
    chk("MemTimeout", 32'(MemTimeout), 32'(m_err && !rst));
`ifdef HAZARD_PERF_EN
    chk("LoadUseCount", LoadUseCount, m_lu);
    chk("MemWaitCount", MemWaitCount, m_mw);
    chk("FlushCount", FlushCount, m_fl);
`else
    chk("LoadUseCount", LoadUseCount, '0);
    chk("MemWaitCount", MemWaitCount, '0);
    chk("FlushCount", FlushCount, '0);
`endif
  endtask

  task automatic update_model();
    bit mem;
    if (rst) begin
      model_reset();
      return;
    end
    mem = e_mem();
    if (e_lu()) m_lu++;
    if (mem) m_mw++;
    if (e_br()) m_fl++;
    if (!m_err) begin
      m_run = mem ? m_run + 1 : 0;
      if (m_run > MW) m_err = 1;
    end
  endtask

  task automatic step();
    @(negedge clk);
    check_model();
    @(posedge clk);
    update_model();
    #1;
  endtask

  task automatic clear_inputs();
    {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
    ResultsSrcE = 0; PCSrcE = 0; RegWriteM = 0; RegWriteW = 0;
    MemAccessM = 0; MemReadyM = 0;
  endtask

  task automatic pulse_reset();
    rst = 1;
    #1 model_reset();
    step();
    rst = 0;
  endtask

  initial begin
    clear_inputs();
    model_reset();
    #1 chk("reset_stallf", 32'(StallF), 0);
    chk("reset_timeout", 32'(MemTimeout), 0);
    step();
    rst = 0;
    step();
    // forwarding
    RdM = 5; RdW = 5; RegWriteM = 1; RegWriteW = 1; Rs1E = 5;
    #1 chk("fwd_m", 32'(ForwardAE), 32'(2'b10));
    RegWriteM = 0;
    #1 chk("fwd_w", 32'(ForwardAE), 32'(2'b01));
    RdW = 0;
    #1 chk("fwd_rd0", 32'(ForwardAE), 32'(2'b00));
    step();
    // load-use
    clear_inputs();
    ResultsSrcE = 2'b01; RdE = 3; Rs2D = 3;
    #1 chk("lu_stallf", 32'(StallF), 1);
    chk("lu_stalld", 32'(StallD), 1);
    chk("lu_flushe", 32'(FlushE), 1);
    chk("lu_flushd", 32'(FlushD), 0);
    step();
    ResultsSrcE = 0;
    #1 chk("lu_release", 32'(StallF), 0);
`ifdef HAZARD_PERF_EN
    chk("lu_count", LoadUseCount, 1);
`endif
    // branch plus load-use
    ResultsSrcE = 2'b01; PCSrcE = 1;
    #1 chk("br_flushd", 32'(FlushD), 1);
    chk("br_flushe", 32'(FlushE), 1);
    chk("br_stallf", 32'(StallF), 0);
    step();
    clear_inputs();
    pulse_reset();
    // memory wait of three cycles
    MemAccessM = 1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("mw_stallm", 32'(StallM), 1);
      chk("mw_flushw", 32'(FlushW), 1);
      step();
    end
    MemReadyM = 1;
    #1 chk("mw_ready", 32'(StallM), 0);
    step();
    MemAccessM = 0; MemReadyM = 0;
    #1 chk("mw_idle", 32'(StallF), 0);
`ifdef HAZARD_PERF_EN
    chk("mw_count", MemWaitCount, 3);
`endif
    step();
    // timeout: IDLE miss cycle plus MW wait cycles, then ERROR
    MemAccessM = 1;
    for (int i = 0; i < MW + 1; i++) begin
      #1 chk("to_pending", 32'(MemTimeout), 0);
      step();
    end
    MemAccessM = 0;
    #1 chk("to_timeout", 32'(MemTimeout), 1);
    chk("to_stalle", 32'(StallE), 1);
    step();
    MemReadyM = 1;
    #1 chk("to_absorb", 32'(StallF), 1);
    step();
    MemReadyM = 0;
    rst = 1;
    #1 chk("to_rst_timeout", 32'(MemTimeout), 0);
    chk("to_rst_stall", 32'(StallF), 0);
    model_reset();
    step();
    rst = 0;
    step();
    // asynchronous reset during the second wait cycle
    MemAccessM = 1;
    step();
    step();
    #1 chk("aw_waiting", 32'(StallM), 1);
    rst = 1;
    #1 chk("aw_rst_stallm", 32'(StallM), 0);
    chk("aw_rst_flushw", 32'(FlushW), 0);
    model_reset();
    step();
    rst = 0;
    MemAccessM = 0;
    step();
    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      Rs1D = 5'($urandom_range(0, 3)); Rs2D = 5'($urandom_range(0, 3));
      Rs1E = 5'($urandom_range(0, 3)); Rs2E = 5'($urandom_range(0, 3));
      RdE = 5'($urandom_range(0, 3)); RdM = 5'($urandom_range(0, 3));
      RdW = 5'($urandom_range(0, 3));
      ResultsSrcE = 2'($urandom_range(0, 3));
      PCSrcE = ($urandom_range(0, 3) == 0);
      RegWriteM = 1'($urandom); RegWriteW = 1'($urandom);
      MemAccessM = ($urandom_range(0, 2) == 0);
      MemReadyM = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 60) == 0) begin
        rst = 1;
        #1 model_reset();
      end else begin
        rst = 0;
      end
      step();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
